axi4_cmd_master: RTL and testbench

- Upstream stage for the AXI4 register-bank slave. Converts a simple single-word command interface (read or write, address, data, strobe, ID) into single-beat AXI4 transactions on the MEM_* channels.
- Collects the B or R response and returns it, with a measured latency, on a response interface.
- One transaction is outstanding at a time. Used by the bench traffic generator and by on-chip configuration logic.

---
 rtl/axi4_cmd_master.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_axi4_cmd_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_cmd_master.sv
// -----------------------------------------------------------------------------
// axi4_cmd_master
//
// Converts a single-word command (read or write) into one single-beat AXI4
// transaction on the MEM_* channels, collects the B or R response and returns
// it on the rsp_* interface together with the measured latency. Only one
// transaction is in flight at a time.
//
// Handshake rule used on every channel (cmd, rsp, AW, W, B, AR, R): a transfer
// happens on the rising ACLK edge where VALID and READY are both high. A VALID
// driven by this block never drops before its READY, and its payload is held
// stable while VALID is high. READY never waits on VALID.
//
// Ports
//   ACLK, ARESET        clock, synchronous active-high reset
//   cmd_*               command in (valid/ready), write flag, id, addr, data, strb
//   rsp_*               response out (valid/ready), write flag, id, resp, rdata,
//                       latency (accept to B/R handshake, saturating)
//   MEM_AW*/W*/B*       AXI4 write address, write data, write response
//   MEM_AR*/R*          AXI4 read address, read data
//   dbg_state_o         current FSM state, for observation only
// -----------------------------------------------------------------------------
module axi4_cmd_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int RESP_WIDTH = 2,
    parameter int LAT_WIDTH  = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [ID_WIDTH-1:0]     rsp_id,
    output logic [RESP_WIDTH-1:0]   rsp_resp,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [LAT_WIDTH-1:0]    rsp_latency,

    output logic [ID_WIDTH-1:0]     MEM_AWID,
    output logic [ADDR_WIDTH-1:0]   MEM_AWADDR,
    output logic [7:0]              MEM_AWLEN,
    output logic [2:0]              MEM_AWSIZE,
    output logic [1:0]              MEM_AWBURST,
    output logic                    MEM_AWLOCK,
    output logic [3:0]              MEM_AWCACHE,
    output logic [2:0]              MEM_AWPROT,
    output logic [3:0]              MEM_AWQOS,
    output logic                    MEM_AWVALID,
    input  logic                    MEM_AWREADY,

    output logic [DATA_WIDTH-1:0]   MEM_WDATA,
    output logic [DATA_WIDTH/8-1:0] MEM_WSTRB,
    output logic                    MEM_WLAST,
    output logic                    MEM_WVALID,
    input  logic                    MEM_WREADY,

    input  logic [ID_WIDTH-1:0]     MEM_BID,
    input  logic [RESP_WIDTH-1:0]   MEM_BRESP,
    input  logic                    MEM_BVALID,
    output logic                    MEM_BREADY,

    output logic [ID_WIDTH-1:0]     MEM_ARID,
    output logic [ADDR_WIDTH-1:0]   MEM_ARADDR,
    output logic [7:0]              MEM_ARLEN,
    output logic [2:0]              MEM_ARSIZE,
    output logic [1:0]              MEM_ARBURST,
    output logic                    MEM_ARLOCK,
    output logic [3:0]              MEM_ARCACHE,
    output logic [2:0]              MEM_ARPROT,
    output logic [3:0]              MEM_ARQOS,
    output logic                    MEM_ARVALID,
    input  logic                    MEM_ARREADY,

    input  logic [ID_WIDTH-1:0]     MEM_RID,
    input  logic [DATA_WIDTH-1:0]   MEM_RDATA,
    input  logic [RESP_WIDTH-1:0]   MEM_RRESP,
    input  logic                    MEM_RLAST,
    input  logic                    MEM_RVALID,
    output logic                    MEM_RREADY,

    output logic [2:0]              dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    // Every beat is one full data-bus word.
    localparam logic [2:0] AX_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2'b10);

    state_t                    state_q, state_d;
    logic                      aw_valid_q, aw_valid_d;
    logic                      w_valid_q, w_valid_d;
    logic                      ar_valid_q, ar_valid_d;
    logic [ID_WIDTH-1:0]       id_q, id_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic [LAT_WIDTH-1:0]      lat_q, lat_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_write_q, rsp_write_d;
    logic [ID_WIDTH-1:0]       rsp_id_q, rsp_id_d;
    logic [RESP_WIDTH-1:0]     rsp_resp_q, rsp_resp_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [LAT_WIDTH-1:0]      rsp_lat_q, rsp_lat_d;
    logic                      aw_done, w_done;
    logic [LAT_WIDTH-1:0]      lat_inc;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    assign lat_inc = (lat_q == '1) ? lat_q : lat_q + 1'b1;

    // A write channel is done once its VALID has dropped or is handshaking now.
    assign aw_done = !aw_valid_q || MEM_AWREADY;
    assign w_done  = !w_valid_q  || MEM_WREADY;

    always_comb begin
        state_d     = state_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        ar_valid_d  = ar_valid_q;
        id_d        = id_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_id_d    = rsp_id_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_lat_d   = rsp_lat_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    id_d    = cmd_id;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    lat_d   = LAT_WIDTH'(1);
                    if (cmd_write) begin
                        state_d    = S_WR_REQ;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = S_RD_REQ;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            S_WR_REQ: begin
                lat_d = lat_inc;
                if (aw_valid_q && MEM_AWREADY) aw_valid_d = 1'b0;
                if (w_valid_q && MEM_WREADY)   w_valid_d  = 1'b0;
                if (aw_done && w_done)         state_d    = S_WR_RESP;
            end
            S_WR_RESP: begin
                lat_d = lat_inc;
                if (MEM_BVALID) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_id_d    = MEM_BID;
                    rsp_resp_d  = MEM_BRESP;
                    rsp_rdata_d = '0;
                    rsp_lat_d   = lat_inc;
                    state_d     = S_RSP;
                end
            end
            S_RD_REQ: begin
                lat_d = lat_inc;
                if (MEM_ARREADY) begin
                    ar_valid_d = 1'b0;
                    state_d    = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                lat_d = lat_inc;
                if (MEM_RVALID) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_id_d    = MEM_RID;
                    // A single-beat read must end with RLAST; anything else is
                    // reported as a slave error rather than silently accepted.
                    rsp_resp_d  = MEM_RLAST ? MEM_RRESP : RESP_SLVERR;
                    rsp_rdata_d = MEM_RDATA;
                    rsp_lat_d   = lat_inc;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            lat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_resp_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_lat_q   <= '0;
        end else begin
            state_q     <= state_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            ar_valid_q  <= ar_valid_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            lat_q       <= lat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_id_q    <= rsp_id_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_lat_q   <= rsp_lat_d;
        end
    end

    // Ready signals are pure state decodes so they never depend on VALID.
    assign cmd_ready   = (state_q == S_IDLE);
    assign MEM_BREADY  = (state_q == S_WR_RESP);
    assign MEM_RREADY  = (state_q == S_RD_RESP);
    assign dbg_state_o = state_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_latency = rsp_lat_q;

    // The command registers feed both address channels; only the channel
    // whose VALID is high carries a meaningful payload.
    assign MEM_AWID    = id_q;
    assign MEM_AWADDR  = addr_q;
    assign MEM_AWLEN   = 8'd0;
    assign MEM_AWSIZE  = AX_SIZE;
    assign MEM_AWBURST = 2'b01;
    assign MEM_AWLOCK  = 1'b0;
    assign MEM_AWCACHE = 4'd0;
    assign MEM_AWPROT  = 3'd0;
    assign MEM_AWQOS   = 4'd0;
    assign MEM_AWVALID = aw_valid_q;

    assign MEM_WDATA   = wdata_q;
    assign MEM_WSTRB   = wstrb_q;
    assign MEM_WLAST   = w_valid_q;
    assign MEM_WVALID  = w_valid_q;

    assign MEM_ARID    = id_q;
    assign MEM_ARADDR  = addr_q;
    assign MEM_ARLEN   = 8'd0;
    assign MEM_ARSIZE  = AX_SIZE;
    assign MEM_ARBURST = 2'b01;
    assign MEM_ARLOCK  = 1'b0;
    assign MEM_ARCACHE = 4'd0;
    assign MEM_ARPROT  = 3'd0;
    assign MEM_ARQOS   = 4'd0;
    assign MEM_ARVALID = ar_valid_q;

endmodule

// File: tb/tb_axi4_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_cmd_master
//
// Drives directed single-word commands through axi4_cmd_master, plays the AXI
// slave side with per-vector wait states, and checks every response against
// hand-computed values in a vector table. Also covers unexpected B/R traffic
// in IDLE and reset in the middle of a write.
// -----------------------------------------------------------------------------
module tb_axi4_cmd_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int RW = 2;
    localparam int LW = 4;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [IW-1:0] cmd_id;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [IW-1:0] rsp_id;
    logic [RW-1:0] rsp_resp;
    logic [DW-1:0] rsp_rdata;
    logic [LW-1:0] rsp_latency;
    logic [IW-1:0] MEM_AWID, MEM_ARID, MEM_BID, MEM_RID;
    logic [AW-1:0] MEM_AWADDR, MEM_ARADDR;
    logic [7:0]    MEM_AWLEN, MEM_ARLEN;
    logic [2:0]    MEM_AWSIZE, MEM_ARSIZE, MEM_AWPROT, MEM_ARPROT;
    logic [1:0]    MEM_AWBURST, MEM_ARBURST;
    logic          MEM_AWLOCK, MEM_ARLOCK;
    logic [3:0]    MEM_AWCACHE, MEM_ARCACHE, MEM_AWQOS, MEM_ARQOS;
    logic          MEM_AWVALID, MEM_AWREADY, MEM_WVALID, MEM_WREADY, MEM_WLAST;
    logic [DW-1:0] MEM_WDATA, MEM_RDATA;
    logic [3:0]    MEM_WSTRB;
    logic [RW-1:0] MEM_BRESP, MEM_RRESP;
    logic          MEM_BVALID, MEM_BREADY, MEM_ARVALID, MEM_ARREADY;
    logic          MEM_RLAST, MEM_RVALID, MEM_RREADY;
    logic [2:0]    dbg_state_o;

    int checks = 0;
    int errors = 0;

    // Slave memory: word-addressed, valid below 0x400, DECERR above.
    logic [31:0] mem [logic [31:0]];

    typedef struct {
        logic        wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_wait;    // AW (or AR) ready delay
        int          w_wait;     // W ready delay
        int          resp_wait;  // B/R valid delay
        logic        rlast;
        logic [3:0]  id_flip;    // slave returns id ^ id_flip
        int          hold;       // cycles rsp_ready stays low
        logic [1:0]  exp_resp;
        logic [3:0]  exp_id;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_lat;
    } vec_t;

    vec_t vecs[13];

    axi4_cmd_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
        .RESP_WIDTH(RW), .LAT_WIDTH(LW)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_id(rsp_id), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .rsp_latency(rsp_latency),
        .MEM_AWID(MEM_AWID), .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN),
        .MEM_AWSIZE(MEM_AWSIZE), .MEM_AWBURST(MEM_AWBURST), .MEM_AWLOCK(MEM_AWLOCK),
        .MEM_AWCACHE(MEM_AWCACHE), .MEM_AWPROT(MEM_AWPROT), .MEM_AWQOS(MEM_AWQOS),
        .MEM_AWVALID(MEM_AWVALID), .MEM_AWREADY(MEM_AWREADY),
        .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
        .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
        .MEM_BID(MEM_BID), .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY),
        .MEM_ARID(MEM_ARID), .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN),
        .MEM_ARSIZE(MEM_ARSIZE), .MEM_ARBURST(MEM_ARBURST), .MEM_ARLOCK(MEM_ARLOCK),
        .MEM_ARCACHE(MEM_ARCACHE), .MEM_ARPROT(MEM_ARPROT), .MEM_ARQOS(MEM_ARQOS),
        .MEM_ARVALID(MEM_ARVALID), .MEM_ARREADY(MEM_ARREADY),
        .MEM_RID(MEM_RID), .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP),
        .MEM_RLAST(MEM_RLAST), .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY),
        .dbg_state_o(dbg_state_o)
    );

    // Clock
    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        MEM_AWREADY = 0; MEM_WREADY = 0; MEM_ARREADY = 0;
        MEM_BVALID = 0; MEM_BID = 0; MEM_BRESP = 0;
        MEM_RVALID = 0; MEM_RID = 0; MEM_RDATA = 0; MEM_RRESP = 0; MEM_RLAST = 0;
    endtask

    // Present one command and accept it.
    task automatic send_cmd(input vec_t v);
        cmd_valid = 1; cmd_write = v.wr; cmd_id = v.id;
        cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        tick();
        cmd_valid = 0;
    endtask

    // Full transaction: command, slave side with wait states, response phase.
    task automatic run_txn(input int idx, input vec_t v);
        bit aw_seen = 0, w_seen = 0, aw_hs, w_hs, ar_seen = 0;
        int cyc = 0;
        logic [31:0] word;
        logic [1:0]  sresp;
        sresp = (v.addr < 32'h400) ? 2'b00 : 2'b11;
        send_cmd(v);
        if (v.wr) begin
            while (!(aw_seen && w_seen)) begin
                if (cyc > 100) begin
                    errors++;
                    $display("FAIL wr_req_timeout vec %0d: handshakes not complete", idx);
                    break;
                end
                MEM_AWREADY = (cyc >= v.aw_wait);
                MEM_WREADY  = (cyc >= v.w_wait);
                check("awvalid", MEM_AWVALID, !aw_seen);
                check("wvalid", MEM_WVALID, !w_seen);
                if (!aw_seen)
                    check("aw_payload",
                          {MEM_AWID, MEM_AWADDR, MEM_AWLEN, MEM_AWSIZE, MEM_AWBURST,
                           MEM_AWLOCK, MEM_AWCACHE, MEM_AWPROT, MEM_AWQOS},
                          {v.id, v.addr, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0});
                if (!w_seen)
                    check("w_payload", {MEM_WDATA, MEM_WSTRB, MEM_WLAST}, {v.wdata, v.wstrb, 1'b1});
                aw_hs = MEM_AWVALID && MEM_AWREADY;
                w_hs  = MEM_WVALID && MEM_WREADY;
                tick();
                aw_seen = aw_seen | aw_hs;
                w_seen  = w_seen | w_hs;
                cyc++;
            end
            MEM_AWREADY = 0; MEM_WREADY = 0;
            if (v.addr < 32'h400) begin
                word = mem.exists(v.addr) ? mem[v.addr] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (v.wstrb[b]) word[8*b +: 8] = v.wdata[8*b +: 8];
                mem[v.addr] = word;
            end
            for (int i = 0; i < v.resp_wait; i++) begin
                check("bready_wait", MEM_BREADY, 1'b1);
                tick();
            end
            MEM_BVALID = 1; MEM_BID = v.id ^ v.id_flip; MEM_BRESP = sresp;
            check("bready", MEM_BREADY, 1'b1);
            tick();
            MEM_BVALID = 0;
            check("bready_after", MEM_BREADY, 1'b0);
        end else begin
            while (!ar_seen) begin
                if (cyc > 100) begin
                    errors++;
                    $display("FAIL rd_req_timeout vec %0d: AR handshake missing", idx);
                    break;
                end
                MEM_ARREADY = (cyc >= v.aw_wait);
                check("arvalid", MEM_ARVALID, 1'b1);
                check("ar_payload",
                      {MEM_ARID, MEM_ARADDR, MEM_ARLEN, MEM_ARSIZE, MEM_ARBURST,
                       MEM_ARLOCK, MEM_ARCACHE, MEM_ARPROT, MEM_ARQOS},
                      {v.id, v.addr, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0});
                ar_seen = MEM_ARVALID && MEM_ARREADY;
                tick();
                cyc++;
            end
            MEM_ARREADY = 0;
            check("arvalid_after", MEM_ARVALID, 1'b0);
            for (int i = 0; i < v.resp_wait; i++) begin
                check("rready_wait", MEM_RREADY, 1'b1);
                tick();
            end
            MEM_RVALID = 1; MEM_RID = v.id ^ v.id_flip; MEM_RRESP = sresp; MEM_RLAST = v.rlast;
            MEM_RDATA = (v.addr < 32'h400 && mem.exists(v.addr)) ? mem[v.addr] : 32'h0;
            check("rready", MEM_RREADY, 1'b1);
            tick();
            MEM_RVALID = 0; MEM_RLAST = 0;
            check("rready_after", MEM_RREADY, 1'b0);
        end
        // Response phase, optionally back-pressured.
        for (int i = 0; i <= v.hold; i++) begin
            check("rsp_valid", rsp_valid, 1'b1);
            check("rsp_fields", {rsp_write, rsp_id, rsp_resp, rsp_rdata, rsp_latency},
                  {v.wr, v.exp_id, v.exp_resp, v.exp_rdata, v.exp_lat});
            check("cmd_ready_rsp", cmd_ready, 1'b0);
            if (i == v.hold) rsp_ready = 1;
            tick();
        end
        rsp_ready = 0;
        check("rsp_valid_done", rsp_valid, 1'b0);
        check("state_idle_done", dbg_state_o, 3'd0);
    endtask

    initial begin
        // Reset
        idle_inputs();
        ARESET = 1;
        repeat (3) tick();
        ARESET = 0;
        check("reset_state", dbg_state_o, 3'd0);
        check("reset_valids", {MEM_AWVALID, MEM_WVALID, MEM_ARVALID, rsp_valid}, 4'b0000);
        check("reset_rsp", {rsp_write, rsp_id, rsp_resp, rsp_rdata, rsp_latency}, '0);
        check("reset_fields", {MEM_AWADDR, MEM_WDATA, MEM_WSTRB, MEM_ARADDR}, '0);
        check("reset_cmd_ready", cmd_ready, 1'b1);

        // Unexpected B/R while idle must not be accepted.
        MEM_BVALID = 1; MEM_RVALID = 1;
        check("unexp_ready", {MEM_BREADY, MEM_RREADY}, 2'b00);
        tick();
        check("unexp_stays_idle", dbg_state_o, 3'd0);
        MEM_BVALID = 0; MEM_RVALID = 0;

        //          wr    id     addr       wdata         strb  aw w  rw  rl  flip   hold resp   eid    erdata        lat
        vecs[0]  = '{1'b1, 4'd3,  32'h10,  32'hDEADBEEF, 4'hF, 0, 0, 0,  1'b1, 4'd0, 0,  2'b00, 4'd3,  32'h0,        4'd3};
        vecs[1]  = '{1'b0, 4'd5,  32'h10,  32'h0,        4'h0, 0, 0, 0,  1'b1, 4'd0, 0,  2'b00, 4'd5,  32'hDEADBEEF, 4'd3};
        vecs[2]  = '{1'b1, 4'd1,  32'h400, 32'h11111111, 4'hF, 0, 0, 0,  1'b1, 4'd0, 0,  2'b11, 4'd1,  32'h0,        4'd3};
        vecs[3]  = '{1'b0, 4'd2,  32'h400, 32'h0,        4'h0, 0, 0, 0,  1'b1, 4'd0, 0,  2'b11, 4'd2,  32'h0,        4'd3};
        vecs[4]  = '{1'b1, 4'd7,  32'h20,  32'h12345678, 4'h3, 5, 0, 0,  1'b1, 4'd0, 0,  2'b00, 4'd7,  32'h0,        4'd8};
        vecs[5]  = '{1'b0, 4'd7,  32'h20,  32'h0,        4'h0, 0, 0, 0,  1'b1, 4'd0, 10, 2'b00, 4'd7,  32'h00005678, 4'd3};
        vecs[6]  = '{1'b1, 4'd4,  32'h24,  32'hA5A5A5A5, 4'hF, 0, 3, 2,  1'b1, 4'd0, 0,  2'b00, 4'd4,  32'h0,        4'd8};
        vecs[7]  = '{1'b0, 4'd9,  32'h24,  32'h0,        4'h0, 0, 0, 40, 1'b1, 4'd0, 0,  2'b00, 4'd9,  32'hA5A5A5A5, 4'd15};
        vecs[8]  = '{1'b0, 4'd6,  32'h10,  32'h0,        4'h0, 0, 0, 0,  1'b0, 4'd0, 0,  2'b10, 4'd6,  32'hDEADBEEF, 4'd3};
        vecs[9]  = '{1'b1, 4'd15, 32'h3FC, 32'hCAFEF00D, 4'hC, 2, 2, 0,  1'b1, 4'd0, 2,  2'b00, 4'd15, 32'h0,        4'd5};
        vecs[10] = '{1'b0, 4'd15, 32'h3FC, 32'h0,        4'h0, 3, 0, 1,  1'b1, 4'd0, 0,  2'b00, 4'd15, 32'hCAFE0000, 4'd7};
        vecs[11] = '{1'b0, 4'd2,  32'h10,  32'h0,        4'h0, 0, 0, 0,  1'b1, 4'd4, 0,  2'b00, 4'd6,  32'hDEADBEEF, 4'd3};
        vecs[12] = '{1'b1, 4'd8,  32'h30,  32'h0BADF00D, 4'hF, 9, 12, 6, 1'b1, 4'd1, 3,  2'b00, 4'd9,  32'h0,        4'd15};

        for (int i = 0; i < 13; i++) run_txn(i, vecs[i]);

        // Reset while WR_REQ waits on AWREADY/WREADY.
        send_cmd('{1'b1, 4'd5, 32'h40, 32'h55AA55AA, 4'hF, 0, 0, 0, 1'b1, 4'd0, 0,
                   2'b00, 4'd5, 32'h0, 4'd0});
        tick();
        check("mid_state_wr_req", dbg_state_o, 3'd1);
        check("mid_valids", {MEM_AWVALID, MEM_WVALID}, 2'b11);
        ARESET = 1;
        tick();
        ARESET = 0;
        check("rst_mid_valids", {MEM_AWVALID, MEM_WVALID, MEM_ARVALID, rsp_valid}, 4'b0000);
        check("rst_mid_state", dbg_state_o, 3'd0);
        check("rst_mid_cmd_ready", cmd_ready, 1'b1);

        // The block is usable again straight after the abandoned write.
        run_txn(13, '{1'b0, 4'd3, 32'h10, 32'h0, 4'h0, 1, 0, 0, 1'b1, 4'd0, 0,
                      2'b00, 4'd3, 32'hDEADBEEF, 4'd4});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
